// File: rtl/ex_mdu_sequencer.sv
// Iterative multiply/divide unit beside the EX-stage ALU: shift-add MUL/MULHU,
// restoring DIVU/REMU, one iteration per cycle with a pipeline stall while running.
module ex_mdu_sequencer #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] opa,
   input  logic [XLEN-1:0] opb,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

   state_t            state, state_n;
   logic [CNT_W-1:0]  count, count_n;
   logic [1:0]        op_q, op_n;
   logic [XLEN-1:0]   opb_q, opb_n;
   logic [XLEN-1:0]   hi, hi_n;
   logic [XLEN-1:0]   lo, lo_n;
   logic [XLEN-1:0]   result_q, result_n;
   logic              done_q, done_n;

   logic [XLEN:0]     sum;
   logic [XLEN:0]     shifted;
   logic [XLEN:0]     diff;
   logic [XLEN-1:0]   step_hi;
   logic [XLEN-1:0]   step_lo;

   // One iteration of the datapath. hi/lo hold {hi,lo} for multiply and {rem,quo} for divide.
   always_comb begin
      step_hi = hi;
      step_lo = lo;
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
      shifted = {hi, lo[XLEN-1]};
      diff    = shifted - {1'b0, opb_q};
      if (!op_q[1]) begin
         step_hi = sum[XLEN:1];
         step_lo = {sum[0], lo[XLEN-1:1]};
      end else if (!diff[XLEN]) begin
         step_hi = diff[XLEN-1:0];
         step_lo = {lo[XLEN-2:0], 1'b1};
      end else begin
         step_hi = shifted[XLEN-1:0];
         step_lo = {lo[XLEN-2:0], 1'b0};
      end
   end

   // Next-state, datapath-next and output logic.
   always_comb begin
      state_n  = state;
      count_n  = count;
      op_n     = op_q;
      opb_n    = opb_q;
      hi_n     = hi;
      lo_n     = lo;
      result_n = result_q;
      done_n   = 1'b0;
      stall    = 1'b0;

      case (state)
         S_IDLE: begin
            if (start && !flush) begin
               stall   = 1'b1;
               op_n    = op;
               opb_n   = opb;
               hi_n    = '0;
               lo_n    = opa;
               count_n = '0;
               if (op[1] && (opb == '0)) begin
                  // Divide by zero retires immediately: all-ones quotient, dividend remainder.
                  state_n  = S_DONE;
                  done_n   = 1'b1;
                  result_n = op[0] ? opa : '1;
               end else begin
                  state_n = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (flush) begin
               state_n = S_IDLE;
               count_n = '0;
            end else begin
               stall   = 1'b1;
               hi_n    = step_hi;
               lo_n    = step_lo;
               count_n = count + CNT_W'(1);
               if (count == LAST_ITER) begin
                  state_n  = S_DONE;
                  done_n   = 1'b1;
                  result_n = op_q[0] ? step_hi : step_lo;
               end
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

      if (reset) begin
         stall = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         count    <= '0;
         op_q     <= '0;
         opb_q    <= '0;
         hi       <= '0;
         lo       <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_n;
         count    <= count_n;
         op_q     <= op_n;
         opb_q    <= opb_n;
         hi       <= hi_n;
         lo       <= lo_n;
         result_q <= result_n;
         done_q   <= done_n;
      end
   end

   assign busy   = (state != S_IDLE);
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_ex_mdu_sequencer.sv
// Bench for ex_mdu_sequencer: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written flush/reset/held-start sequences.
module tb_ex_mdu_sequencer;

   localparam int unsigned XLEN = 32;

   logic            clk;
   logic            reset;
   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] opa;
   logic [XLEN-1:0] opb;
   logic            flush;
   logic            stall;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   int n_checks;
   int n_fail;

   ex_mdu_sequencer #(.XLEN(XLEN), .CNT_W(6)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .opa    (opa),
      .opb    (opb),
      .flush  (flush),
      .stall  (stall),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_res;
      int          exp_lat;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: plain 64-bit arithmetic, RISC-V divide-by-zero rules.
   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = 64'(a) * 64'(b);
      case (o)
         2'b00:   return p[31:0];
         2'b01:   return p[63:32];
         2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int model_lat(input logic [1:0] o, input logic [31:0] b);
      return (o[1] && b == 0) ? 1 : XLEN + 1;
   endfunction

   // Issue one op in IDLE and wait (bounded) for done; counts latency and stall cycles.
   task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int stalls);
      @(negedge clk);
      start = 1'b1; op = o; opa = a; opb = b;
      #1;
      stalls = stall ? 1 : 0;
      lat = 0;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (stall) stalls++;
         start = 1'b0;
         op  = 2'($urandom);
         opa = $urandom;
         opb = $urandom;
         if (done) break;
      end
      res = result;
   endtask

   vec_t        vecs[$];
   logic [31:0] res;
   logic [31:0] prev;
   int          lat;
   int          stalls;
   int          pulses;
   logic [1:0]  ro;
   logic [31:0] ra;
   logic [31:0] rb;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0; flush = 1'b0;
      @(negedge clk);
      start = 1'b1;
      #1;
      chk("stall_in_reset", 64'(stall), 64'd0);
      @(negedge clk);
      start = 1'b0;
      reset = 1'b0;
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);

      // Directed vectors
      vecs.push_back('{2'b00, 32'd7, 32'd6, 32'd42, 33});
      vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
      vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33});
      vecs.push_back('{2'b10, 32'd100, 32'd7, 32'd14, 33});
      vecs.push_back('{2'b11, 32'd100, 32'd7, 32'd2, 33});
      vecs.push_back('{2'b10, 32'h8000_0000, 32'd1, 32'h8000_0000, 33});
      vecs.push_back('{2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF, 1});
      vecs.push_back('{2'b11, 32'd5, 32'd0, 32'd5, 1});
      vecs.push_back('{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33});
      vecs.push_back('{2'b11, 32'd3, 32'hFFFF_FFFF, 32'd3, 33});
      vecs.push_back('{2'b01, 32'h8000_0000, 32'd2, 32'd1, 33});
      for (int i = 0; i < vecs.size(); i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, stalls);
         chk($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].exp_res));
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
         chk($sformatf("vec%0d_stalls", i), 64'(stalls), 64'(vecs[i].exp_lat));
      end

      // Randomized ops against the model
      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom);
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) != 0 ? $urandom : 32'($urandom_range(1, 1000)));
         do_op(ro, ra, rb, res, lat, stalls);
         chk($sformatf("rnd%0d_result op=%0d a=%0h b=%0h", i, ro, ra, rb), 64'(res), 64'(model(ro, ra, rb)));
         chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(model_lat(ro, rb)));
      end

      // Flush in RUN at count 10: no done, result kept, stall drops immediately
      do_op(2'b00, 32'd11, 32'd13, prev, lat, stalls);
      chk("pre_flush_result", 64'(prev), 64'd143);
      @(negedge clk);
      start = 1'b1; op = 2'b00; opa = 32'd3; opb = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      #1;
      chk("flush_stall_same_cycle", 64'(stall), 64'd0);
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", 64'(busy), 64'd0);
      chk("flush_done", 64'(done), 64'd0);
      chk("flush_result", 64'(result), 64'(prev));
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("flush_no_done_pulse", 64'(pulses), 64'd0);
      chk("flush_result_held", 64'(result), 64'(prev));
      do_op(2'b10, 32'd9, 32'd3, res, lat, stalls);
      chk("after_flush_divu", 64'(res), 64'd3);
      chk("after_flush_lat", 64'(lat), 64'd33);

      // Flush in the accept cycle blocks the accept
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = 2'b00; opa = 32'd2; opb = 32'd2;
      #1;
      chk("flush_accept_stall", 64'(stall), 64'd0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("flush_accept_busy", 64'(busy), 64'd0);

      // Flush while in DONE: the op still retires
      @(negedge clk);
      start = 1'b1; op = 2'b11; opa = 32'd17; opb = 32'd0;
      @(negedge clk);
      start = 1'b0; flush = 1'b1;
      chk("flush_done_pulse", 64'(done), 64'd1);
      chk("flush_done_result", 64'(result), 64'd17);
      @(negedge clk);
      flush = 1'b0;
      chk("flush_done_idle", 64'(busy), 64'd0);

      // start held high through DONE: exactly one op
      @(negedge clk);
      start = 1'b1; op = 2'b00; opa = 32'd5; opb = 32'd9;
      pulses = 0;
      lat = 0;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (done) begin
            pulses++;
            break;
         end
      end
      chk("held_start_latency", 64'(lat), 64'd33);
      chk("held_start_result", 64'(result), 64'd45);
      // start was high during the DONE edge; drop it before IDLE can accept
      start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("held_start_pulses", 64'(pulses), 64'd1);
      chk("held_start_busy", 64'(busy), 64'd0);

      // Reset pulsed at count 5 clears everything
      @(negedge clk);
      start = 1'b1; op = 2'b01; opa = 32'hDEAD_BEEF; opb = 32'h1234_5678;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midop_reset_stall", 64'(stall), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      chk("midop_reset_busy", 64'(busy), 64'd0);
      chk("midop_reset_done", 64'(done), 64'd0);
      chk("midop_reset_result", 64'(result), 64'd0);
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("midop_reset_no_done", 64'(pulses), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
